// File: rtl/prio_pkg.sv
// Shared constants and width helpers for the pending priority encoder.
package prio_pkg;

    // Code presented on out_code while no grant is held.
    localparam logic [7:0] EMPTY_CODE_DEF = 8'hF0;

    // Bits needed to hold an index 0..n-1 (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed to hold a count 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational circular priority picker: scans downward from 'start',
// wrapping from 0 to N-1, and returns the first set candidate.
module prio_pick #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     cand,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W-1:0] pos;

    // First hit wins; later positions in scan order are ignored.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int i = 0; i < N; i++) begin
            pos = (int'(start) >= i) ? IDX_W'(int'(start) - i)
                                     : IDX_W'(int'(start) - i + N);
            if (!found && cand[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/pend_prio_encoder.sv
// Pending-request priority encoder with a one-deep valid/ready output stage.
// Requests are latched into a pending register; one unmasked pending line is
// granted per free output slot and cleared from the register on that edge.
// Build option: define PEND_PRIO_RR_EN for round-robin selection; the
// default build uses fixed priority (highest index first).
module pend_prio_encoder
    import prio_pkg::*;
#(
    parameter int               N          = 16,
    parameter int               OUT_W      = 8,
    parameter logic [OUT_W-1:0] EMPTY_CODE = EMPTY_CODE_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            req_i,
    input  logic [N-1:0]            mask_i,
    input  logic                    clr_i,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_code,
    output logic [cnt_width(N)-1:0] pend_cnt,
    output logic                    coll
);

    localparam int IDX_W = idx_width(N);
    localparam int CNT_W = cnt_width(N);

    logic [N-1:0]     pend;
    logic [N-1:0]     cand;
    logic [N-1:0]     load_onehot;
    logic [N-1:0]     pend_nxt;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] start_idx;
    logic             found;
    logic             stage_free;
    logic             load;
    logic             coll_hit;
    logic [CNT_W-1:0] cnt_nxt;

    assign cand       = pend & ~mask_i;
    assign stage_free = !out_valid || out_ready;
    assign load       = stage_free && found;

    prio_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .cand  (cand),
        .start (start_idx),
        .idx   (sel_idx),
        .found (found)
    );

`ifdef PEND_PRIO_RR_EN
    logic [IDX_W-1:0] ptr;

    assign start_idx = ptr;

    // Round-robin pointer: next search begins just below the last grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= IDX_W'(N - 1);
        end else if (clr_i) begin
            ptr <= IDX_W'(N - 1);
        end else if (load) begin
            ptr <= (sel_idx == '0) ? IDX_W'(N - 1) : sel_idx - 1'b1;
        end
    end
`else
    // Fixed priority is a scan that always starts at the top line.
    assign start_idx = IDX_W'(N - 1);
`endif

    // One-hot of the line being moved into the output stage this edge.
    always_comb begin
        load_onehot = '0;
        if (load) load_onehot[sel_idx] = 1'b1;
    end

    // New requests OR in after the granted bit is removed, so a request on
    // the granted line re-arms it (set wins) and is not a collision.
    assign pend_nxt = (pend & ~load_onehot) | req_i;
    assign coll_hit = |(req_i & pend & ~load_onehot);

    // Popcount of the next pending value so pend_cnt tracks pend exactly.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < N; i++) cnt_nxt = cnt_nxt + CNT_W'(pend_nxt[i]);
    end

    // Pending register, its count and the sticky collision flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= '0;
            pend_cnt <= '0;
            coll     <= 1'b0;
        end else if (clr_i) begin
            pend     <= '0;
            pend_cnt <= '0;
            coll     <= 1'b0;
        end else begin
            pend     <= pend_nxt;
            pend_cnt <= cnt_nxt;
            if (coll_hit) coll <= 1'b1;
        end
    end

    // Output stage: refills only when empty or being consumed; holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_code  <= EMPTY_CODE;
        end else if (clr_i) begin
            out_valid <= 1'b0;
            out_code  <= EMPTY_CODE;
        end else if (stage_free) begin
            if (found) begin
                out_valid <= 1'b1;
                out_code  <= {{(OUT_W - IDX_W){1'b0}}, sel_idx};
            end else begin
                out_valid <= 1'b0;
                out_code  <= EMPTY_CODE;
            end
        end
    end

endmodule

// File: tb/tb_pend_prio_encoder.sv
// Scoreboard bench for pend_prio_encoder: a behavioural model predicts the
// state after every edge and every accepted grant; monitors compare.
module tb_pend_prio_encoder;

    localparam int         N     = 16;
    localparam logic [7:0] EMPTY = 8'hF0;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_i, mask_i;
    logic          clr_i, out_ready;
    logic          out_valid, coll;
    logic [7:0]    out_code;
    logic [4:0]    pend_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       v;
        logic [7:0] code;
        logic [4:0] cnt;
        logic       coll;
    } snap_t;

    snap_t      exp_q[$];
    logic [7:0] grant_q[$];

    // model state
    logic [N-1:0] m_pend;
    logic         m_valid;
    logic [7:0]   m_code;
    logic         m_coll;
    int           m_ptr;

    pend_prio_encoder #(.N(N), .OUT_W(8), .EMPTY_CODE(8'hF0)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .mask_i    (mask_i),
        .clr_i     (clr_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .pend_cnt  (pend_cnt),
        .coll      (coll)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_valid = 1'b0; m_code = EMPTY; m_coll = 1'b0; m_ptr = N - 1;
    endtask

    // Behaviour of one clock edge, stated directly from the rules.
    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] m,
                              input logic rdy, input logic c);
        int    sel;
        int    cnt;
        snap_t s;
        if (c) begin
            model_reset();
        end else begin
            if (m_valid && rdy) grant_q.push_back(m_code);
            sel = -1;
            if (!m_valid || rdy) begin
                for (int i = 0; i < N; i++) begin
                    int k;
                    k = (m_ptr - i + N) % N;
                    if (sel < 0 && m_pend[k] && !m[k]) sel = k;
                end
            end
            for (int k = 0; k < N; k++)
                if (r[k] && m_pend[k] && k != sel) m_coll = 1'b1;
            for (int k = 0; k < N; k++)
                m_pend[k] = (m_pend[k] && k != sel) || r[k];
            if (!m_valid || rdy) begin
                if (sel >= 0) begin
                    m_valid = 1'b1;
                    m_code  = 8'(sel);
`ifdef PEND_PRIO_RR_EN
                    m_ptr   = (sel + N - 1) % N;
`endif
                end else begin
                    m_valid = 1'b0;
                    m_code  = EMPTY;
                end
            end
        end
        cnt = 0;
        for (int k = 0; k < N; k++) cnt += int'(m_pend[k]);
        s.v = m_valid; s.code = m_code; s.cnt = 5'(cnt); s.coll = m_coll;
        exp_q.push_back(s);
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] m,
                        input logic rdy, input logic c);
        @(negedge clk); #1;
        req_i = r; mask_i = m; out_ready = rdy; clr_i = c;
        model_step(r, m, rdy, c);
    endtask

    // State monitor: one predicted snapshot per edge.
    initial forever begin
        snap_t e;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (out_valid !== e.v || out_code !== e.code || pend_cnt !== e.cnt || coll !== e.coll) begin
                errors++;
                $display("FAIL state: got v=%0b code=%0h cnt=%0d coll=%0b expected v=%0b code=%0h cnt=%0d coll=%0b at %0t",
                         out_valid, out_code, pend_cnt, coll, e.v, e.code, e.cnt, e.coll, $time);
            end
        end
    end

    // Grant monitor: every DUT handshake must match the next predicted grant.
    initial forever begin
        logic [7:0] g;
        @(negedge clk); #2;
        if (!rst && !clr_i && out_valid && out_ready) begin
            if (grant_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL grant: got unexpected code %0h expected none at %0t", out_code, $time);
            end else begin
                g = grant_q.pop_front();
                chk("grant", int'(out_code), int'(g));
            end
        end
    end

    initial begin
        rst = 1'b1; req_i = '0; mask_i = '0; clr_i = 1'b0; out_ready = 1'b0;
        model_reset();
        #12;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_code",  int'(out_code),  int'(EMPTY));
        chk("rst_cnt",   int'(pend_cnt),  0);
        chk("rst_coll",  int'(coll),      0);
        @(negedge clk); #1 rst = 1'b0;

        // two lines in one cycle: top first, then bottom, then empty
        step(16'h8001, '0, 1'b1, 1'b0);
        repeat (4) step('0, '0, 1'b1, 1'b0);

        // stall holds code 4 while line 12 arrives
        step(16'h0010, '0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        step(16'h1000, '0, 1'b0, 1'b0);
        repeat (2) step('0, '0, 1'b0, 1'b0);
        repeat (3) step('0, '0, 1'b1, 1'b0);

        // collision on a held request while the stage is occupied, then flush
        step(16'h0001, '0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        repeat (3) step(16'h0008, '0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b1);
        step('0, '0, 1'b1, 1'b0);

        // masked line stays pending until unmasked
        step(16'h0204, 16'h0200, 1'b1, 1'b0);
        repeat (3) step('0, 16'h0200, 1'b1, 1'b0);
        repeat (3) step('0, '0, 1'b1, 1'b0);

        // all lines held
        repeat (20) step(16'hFFFF, '0, 1'b1, 1'b0);
        step('0, '0, 1'b1, 1'b1);
        step('0, '0, 1'b1, 1'b0);

        // random traffic
        repeat (500) begin
            logic [N-1:0] r, m;
            r = N'($urandom & $urandom & $urandom);
            m = ($urandom_range(0, 3) == 0) ? N'($urandom & $urandom) : '0;
            step(r, m, $urandom_range(0, 9) < 7, $urandom_range(0, 59) == 0);
        end
        step('0, '0, 1'b1, 1'b1);

        // asynchronous reset in the middle of a stall
        step(16'h0040, '0, 1'b0, 1'b0);
        repeat (2) step('0, '0, 1'b0, 1'b0);
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_code",  int'(out_code),  int'(EMPTY));
        chk("arst_cnt",   int'(pend_cnt),  0);
        chk("arst_coll",  int'(coll),      0);
        model_reset();
        @(negedge clk); #1 rst = 1'b0;
        @(negedge clk); #5;

        chk("exp_q_drained",   exp_q.size(),   0);
        chk("grant_q_drained", grant_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pend_prio_encoder.md
PEND_PRIO_ENCODER -- requirements
Module: pend_prio_encoder

Interface
REQ-001 SHALL have parameter N, default 16: number of request lines, 2..64.
REQ-002 SHALL have parameter OUT_W, default 8: code width; index zero-extended, OUT_W >= $clog2(N)+1.
REQ-003 SHALL have parameter EMPTY_CODE, default 8'hF0: value of out_code when out_valid=0.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-006 SHALL have port req_i  in  N  level request lines, sampled every clk.
REQ-007 SHALL have port mask_i  in  N  1 = line blocked from selection; it stays pending.
REQ-008 SHALL have port clr_i  in  1  synchronous flush of all state.
REQ-009 SHALL have port out_valid  out  1  out_code holds a granted index.
REQ-010 SHALL have port out_ready  in  1  consumer accepts when out_valid & out_ready.
REQ-011 SHALL have port out_code  out  OUT_W  granted index, or EMPTY_CODE.
REQ-012 SHALL have port pend_cnt  out  $clog2(N+1)  popcount of the pending register.
REQ-013 SHALL have port coll  out  1  sticky: a request hit an already-pending line.

Function
REQ-014 SHALL keep an N-bit pending register: pend <= (pend & ~load_onehot) | req_i each cycle.
REQ-015 SHALL compute candidates = pend & ~mask_i and select one per the priority rule (REQ-016, REQ-026).
REQ-016 SHALL, in fixed mode, select the highest set index (bit N-1 highest, bit 0 lowest).
REQ-017 SHALL load the output stage when (!out_valid | out_ready) and candidates != 0: out_valid<=1, out_code<=index, selected bit cleared from pend the same edge.
REQ-018 SHALL drop out_valid to 0 and set out_code to EMPTY_CODE after acceptance if no candidate exists.
REQ-019 SHALL hold out_code and out_valid stable while out_valid & !out_ready, whatever req_i/mask_i do.
REQ-020 SHALL give latency 2 cycles: req_i high at edge t sets pend at t; out_valid at edge t+1 when the stage is free.
REQ-021 SHALL keep the selected bit set when req_i on that bit coincides with its load edge (set wins), without setting coll.
REQ-022 SHALL set coll when req_i[k]=1 and pend[k]=1 and bit k is not being loaded that edge; coll clears only on rst or clr_i.
REQ-023 SHALL, on clr_i=1, clear pend, out_valid, coll and set out_code=EMPTY_CODE; clr_i overrides req_i and out_ready in the same cycle.
REQ-024 SHALL report pend_cnt as the registered popcount of pend, masked bits included.

Reset
REQ-025 SHALL, while rst=1, immediately force pend=0, out_valid=0, out_code=EMPTY_CODE, coll=0, pend_cnt=0, RR pointer=N-1; a transaction in flight is lost.

Configuration
REQ-026 SHALL, with macro PEND_PRIO_RR_EN defined, use round-robin: after granting index k, the search starts at k-1 downward and wraps N-1 after 0; the pointer updates only on load.
REQ-027 SHALL, without PEND_PRIO_RR_EN, use fixed priority (REQ-016), with no pointer register present.

Structure
REQ-028 SHALL place EMPTY_CODE default and index-width helper constants in shared package prio_pkg.
REQ-029 SHALL implement selection in combinational sub-module prio_pick (inputs: candidates, start index; outputs: index, found).

Verification
REQ-030 SHALL cover N=16, fixed: req_i=16'h8001 one cycle, out_ready=1 -> codes 15 then 0 on successive cycles, then EMPTY_CODE 8'hF0, pend_cnt 2->1->0.
REQ-031 SHALL cover stall: out_ready=0, code 4 valid, then req_i[12] pulsed -> out_code stays 4 until out_ready=1, then 12.
REQ-032 SHALL cover collision: req_i[3] held 3 cycles with out_ready=0 and stage occupied -> coll=1; clr_i pulse -> coll=0, pend_cnt=0, out_valid=0.
REQ-033 SHALL cover mask: pend bits {9,2}, mask_i[9]=1 -> code 2 granted; pend_cnt=1 with bit 9 retained; unmask -> 9.
REQ-034 SHALL cover RR build: req_i=16'hFFFF held, out_ready=1 -> codes 15,14,...,0,15 cycling; fixed build -> 15 every cycle.
REQ-035 SHALL cover async rst asserted mid-stall with out_valid=1 -> outputs at reset values before next clk edge.
